// File: rtl/hdmi_audio_pkg.sv
// Shared types and helpers for the HDMI audio pacer: pacer state, accumulator
// width and the stereo word packing used on the FIFO input.
package hdmi_audio_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } pacer_state_t;

  localparam int ACC_W = 32;

  function automatic logic [31:0] pack_lr(input logic [15:0] l, input logic [15:0] r);
    return {l, r};
  endfunction

endpackage

// File: rtl/audio_fifo_sync.sv
// DEPTH x 32 synchronous FIFO with a separate occupancy counter; the head is
// read from registered pointers only, so a push never falls through to a pop.
module audio_fifo_sync #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic [31:0]   dout,
  output logic [AW:0]   fill
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (fill != FULL);
  assign do_pop  = pop && (fill != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage is intentionally left out of reset; stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Rate-adapting audio buffer: a FIFO absorbs bursty upstream samples and a
// fractional phase accumulator releases exactly FS_HZ words per second.
module hdmi_audio_pacer
  import hdmi_audio_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int CLK_HZ = 25200000,
  parameter int FS_HZ  = 48000,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clk_pixel,
  input  logic          sys_nrst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_l,
  input  logic [15:0]   in_r,
  output logic [31:0]   out_word,
  output logic          out_tick,
  output logic [AW:0]   fill,
  output logic [15:0]   underrun_cnt
);

  localparam logic [AW:0]      FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0]      HALF   = (AW+1)'(DEPTH / 2);
  localparam logic [ACC_W-1:0] CLK_C  = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] FS_C   = ACC_W'(FS_HZ);

  pacer_state_t     state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_wrap;
  logic             tick;
  logic             push;
  logic             pop;
  logic [31:0]      head;

  // One extra bit on the sum keeps the compare exact; the wrapped value always fits.
  assign acc_sum  = {1'b0, acc} + {1'b0, FS_C};
  assign tick     = acc_sum >= {1'b0, CLK_C};
  assign acc_wrap = acc_sum[ACC_W-1:0] - CLK_C;

  assign in_ready = (fill != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = tick && (state == RUN) && (fill != '0);

  audio_fifo_sync #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk  (clk_pixel),
    .nrst (sys_nrst),
    .push (push),
    .pop  (pop),
    .din  (pack_lr(in_l, in_r)),
    .dout (head),
    .fill (fill)
  );

  always_ff @(posedge clk_pixel) begin
    if (!sys_nrst) begin
      state        <= PRIME;
      acc          <= '0;
      out_word     <= '0;
      out_tick     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      acc      <= tick ? acc_wrap : acc_sum[ACC_W-1:0];
      out_tick <= tick;
      case (state)
        PRIME: begin
          if (fill >= HALF) state <= RUN;
        end
        RUN: begin
          if (tick) begin
            if (fill != '0) begin
              out_word <= head;
            end else begin
              if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
              state <= PRIME;
            end
          end
        end
        default: state <= PRIME;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// Randomized scoreboard bench for hdmi_audio_pacer using a queue-based
// reference model with ticks derived from floor(n*FS/CLK).
module tb_hdmi_audio_pacer;

  localparam int DEPTH  = 16;
  localparam int CLK_HZ = 10;
  localparam int FS_HZ  = 3;
  localparam int AW     = $clog2(DEPTH);

  logic          clk_pixel = 1'b0;
  logic          sys_nrst  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [15:0]   in_l      = '0;
  logic [15:0]   in_r      = '0;
  logic [31:0]   out_word;
  logic          out_tick;
  logic [AW:0]   fill;
  logic [15:0]   underrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  bit rdy_seen = 1'b0;

  typedef struct {
    logic [31:0] word;
    logic [15:0] ucnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mq[$];
  longint      m_n    = 0;
  bit          m_run  = 1'b0;
  logic [31:0] m_word = '0;
  int          m_ucnt = 0;

  hdmi_audio_pacer #(
    .DEPTH  (DEPTH),
    .CLK_HZ (CLK_HZ),
    .FS_HZ  (FS_HZ)
  ) dut (
    .clk_pixel    (clk_pixel),
    .sys_nrst     (sys_nrst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_l         (in_l),
    .in_r         (in_r),
    .out_word     (out_word),
    .out_tick     (out_tick),
    .fill         (fill),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n-th cycle since reset ticks when floor(n*FS/CLK) steps.
  always @(posedge clk_pixel) begin : model
    bit t;
    bit do_push;
    int sz;
    if (!sys_nrst) begin
      mq.delete();
      exp_q.delete();
      m_n    = 0;
      m_run  = 1'b0;
      m_word = '0;
      m_ucnt = 0;
    end else begin
      sz      = mq.size();
      m_n     = m_n + 1;
      t       = ((m_n * FS_HZ) / CLK_HZ) != (((m_n - 1) * FS_HZ) / CLK_HZ);
      do_push = in_valid && (sz != DEPTH);
      if (t) begin
        if (m_run && sz > 0) m_word = mq.pop_front();
        else if (m_run && m_ucnt < 65535) m_ucnt++;
        exp_q.push_back('{m_word, 16'(m_ucnt)});
      end
      if (!m_run) m_run = (sz >= DEPTH / 2);
      else if (t && sz == 0) m_run = 1'b0;
      if (do_push) mq.push_back({in_l, in_r});
    end
  end

  always @(negedge clk_pixel) begin : monitor
    exp_t e;
    if (mon_en && sys_nrst) begin
      checkOutput("out_tick", {31'd0, out_tick}, {31'd0, exp_q.size() != 0});
      if (out_tick && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("out_word", out_word, e.word);
        checkOutput("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, e.ucnt});
      end
      exp_q.delete();
      checkOutput("fill", 32'(fill), 32'(mq.size()));
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
    end
  end

  task automatic applyStimulus(input int cycles, input int pct);
    repeat (cycles) begin
      @(negedge clk_pixel);
      #1;
      if (in_valid && rdy_seen) in_valid = 1'b0;
      if (!in_valid && ($urandom_range(99) < pct)) begin
        in_valid = 1'b1;
        in_l     = 16'($urandom);
        in_r     = 16'($urandom);
      end
      rdy_seen = in_ready;
    end
  endtask

  task automatic resetPulse(input int cycles);
    @(negedge clk_pixel);
    #1;
    sys_nrst = 1'b0;
    in_valid = 1'b0;
    rdy_seen = 1'b0;
    repeat (cycles) @(negedge clk_pixel);
    #1;
    checkOutput("rst_out_word", out_word, 32'd0);
    checkOutput("rst_out_tick", {31'd0, out_tick}, 32'd0);
    checkOutput("rst_fill", 32'(fill), 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
    sys_nrst = 1'b1;
  endtask

  initial begin
    resetPulse(3);
    mon_en = 1'b1;
    applyStimulus(300, 100);
    applyStimulus(150, 0);
    applyStimulus(600, 40);
    applyStimulus(300, 25);
    applyStimulus(200, 70);
    resetPulse(1);
    applyStimulus(400, 60);
    applyStimulus(200, 100);
    applyStimulus(200, 0);
    @(negedge clk_pixel);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_audio_pacer.md
# hdmi_audio_pacer

Rate-adapting audio buffer between the FM demodulator/audio chain and the HDMI audio wrapper's `hdmi_aud` input. It replaces the free-running sample-and-hold counter with two things: a small FIFO, and a fractional phase accumulator that releases exactly FS_HZ stereo words per second of `clk_pixel`. It absorbs bursty upstream delivery through a valid/ready handshake. On starvation it holds the last output word and counts the underrun.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `CLK_HZ`, 25200000: `clk_pixel` frequency in Hz.
- `FS_HZ`, 48000: output sample rate; must be < `CLK_HZ`.
- `AW`, $clog2(DEPTH): address width (derived).

Ports:
- `clk_pixel` in 1: sole clock.
- `sys_nrst` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream sample present.
- `in_ready` out 1: FIFO can accept.
- `in_l` in 16: left sample, two's complement.
- `in_r` in 16: right sample, two's complement.
- `out_word` out 32: {L[15:0], R[15:0]}, feeds `hdmi_aud`.
- `out_tick` out 1: one-cycle strobe, asserted in the cycle `out_word` takes a new value.
- `fill` out AW+1: current FIFO occupancy.
- `underrun_cnt` out 16: saturating count of starved ticks while in RUN.

## Operation
- **Push:** occurs when `in_valid && in_ready`. `in_ready = (fill != DEPTH)`, driven from registered state only. Upstream holds data until accepted.
- **Phase accumulator:** 32 bits wide, `acc`.
  - Each cycle: if `acc + FS_HZ >= CLK_HZ`, then `acc <= acc + FS_HZ - CLK_HZ` and a tick is generated.
  - Otherwise `acc <= acc + FS_HZ`.
  - Long-run tick rate is exactly FS_HZ/CLK_HZ per cycle, with no drift.
- **State machine:**
  - PRIME (reset state): ticks do not pop. `out_word` is held; it is 0 after reset. Move to RUN when `fill >= DEPTH/2`, evaluated every cycle.
  - RUN, tick with `fill != 0`: pop the head into `out_word`.
  - RUN, tick with `fill == 0`: `out_word` is held. `underrun_cnt` increments, saturating at 16'hFFFF. Return to PRIME.
- `out_tick` pulses on every tick in both states, including held-word ticks.
- **Simultaneous push and pop:** `fill` is unchanged. The popped entry is the old head; the pushed data goes to the tail.
- **Push into an empty FIFO on a tick cycle:** no fall-through. The pop sees `fill == 0` and that tick is an underrun if in RUN.
- **Full FIFO:** `in_ready` is low, so no push. A pop in that cycle frees a slot; `in_ready` rises the next cycle.
- **Pointers:** read and write pointers are AW bits and wrap modulo DEPTH. `fill` is tracked as a separate counter.
- **Reset mid-operation:** occurs on the first rising edge with `sys_nrst` low. It clears `acc`, the pointers, `fill`, `underrun_cnt` and `out_word`, and returns the state to PRIME. FIFO contents are discarded; RAM is not cleared.

## Timing
- Reset values: `out_word` = 0, `out_tick` = 0, `fill` = 0, `in_ready` = 1 (from the first cycle after reset), `underrun_cnt` = 0, `acc` = 0.
- Tick decision is made from `acc` in cycle N. In the same registered edge, `out_word` is loaded and `out_tick` is set. Both are visible in cycle N+1, with zero extra pipeline.
- Push-to-`fill` latency: 1 cycle. Push-to-output minimum latency is bounded by PRIME: DEPTH/2 samples must be queued first.
- Tick spacing is either floor(CLK_HZ/FS_HZ) or ceil(CLK_HZ/FS_HZ) cycles. For the defaults it is exactly 525.

## Structure
- Shared package `hdmi_audio_pkg`:
  - state enum {PRIME, RUN};
  - constant `ACC_W` = 32;
  - function packing L/R into the 32-bit word.
- One sub-module, `audio_fifo_sync`: DEPTH×32 synchronous FIFO providing push/pop/fill, with no fall-through.
- Pacer logic (accumulator, FSM, counter) lives in the top.

## Test plan
- **Rate:** CLK_HZ=10, FS_HZ=3, FIFO kept non-empty. Ticks occur at cycles 4, 7, 10, 14, 17, 20 after reset release: spacing pattern 4,3,3, and 3 ticks per 10 cycles.
- **Prime/run:** DEPTH=16 with defaults. Push 7 samples: `out_word` stays 0 and `out_tick` still pulses every 525 cycles. Push an 8th sample {16'h1234,16'hABCD}-first sequence: state moves to RUN and the next tick outputs the first-pushed word.
- **Full:** hold `in_valid` high with no ticks pending. `fill` reaches 16 and `in_ready` drops. At the next tick, `fill` goes to 15 and `in_ready` is 1 the following cycle.
- **Underrun:** in RUN with `fill`=1, stop upstream. First tick outputs the last sample. Second tick holds the word, `underrun_cnt` becomes 1, and the state is PRIME.
- **Simultaneous push and pop:** `fill`=4, push and tick in the same cycle. `fill` stays 4 and the order is preserved.
- **Reset mid-run:** drive `sys_nrst` low for 1 cycle with `fill`=9 and `underrun_cnt`=3. All outputs return to reset values on the next cycle.
